// File: rtl/seq_alu.sv
// seq_alu: multi-cycle ALU with a start/busy/done handshake and iterative signed MUL/DIV.
// Define ALU_FLAGS_EN to add the registered {N,Z,C,V} flags output.
//
// state | meaning
// IDLE  | waiting for start
// ITER  | one radix-2 MUL/DIV step per cycle
// FIX   | sign correction and result write
// DONE  | done pulse, busy low; a new start is accepted here

module seq_alu #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               clr_n,
    input  logic               start,
    input  logic [4:0]         opcode,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] result,
    output logic               div_zero
`ifdef ALU_FLAGS_EN
    ,
    output logic [3:0]         flags
`endif
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam int M  = WIDTH - 1;

    localparam logic [4:0] OP_AND  = 5'b00000;
    localparam logic [4:0] OP_OR   = 5'b00001;
    localparam logic [4:0] OP_NOT  = 5'b00010;
    localparam logic [4:0] OP_NEG  = 5'b00011;
    localparam logic [4:0] OP_ADD  = 5'b00100;
    localparam logic [4:0] OP_SUB  = 5'b00101;
    localparam logic [4:0] OP_MUL  = 5'b00110;
    localparam logic [4:0] OP_DIV  = 5'b00111;
    localparam logic [4:0] OP_SHR  = 5'b01000;
    localparam logic [4:0] OP_SHRA = 5'b01001;
    localparam logic [4:0] OP_SHL  = 5'b01010;
    localparam logic [4:0] OP_ROR  = 5'b01011;
    localparam logic [4:0] OP_ROL  = 5'b01100;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_next;

    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic [WIDTH-1:0]   r_mcand;
    logic               r_sa;
    logic               r_sb;
    logic               r_is_div;
    logic [CW-1:0]      r_cnt;
    logic [2*WIDTH-1:0] r_result;
    logic               r_div_zero;

    logic               w_accept;
    logic               w_iterative;
    logic [SHW-1:0]     w_sh;
    logic [WIDTH-1:0]   w_val;
    logic [2*WIDTH-1:0] w_single;
    logic [WIDTH-1:0]   w_abs_a;
    logic [WIDTH-1:0]   w_abs_b;
    logic [WIDTH:0]     w_sum;
    logic [WIDTH:0]     w_rem_sh;
    logic               w_ge;
    logic [WIDTH-1:0]   w_diff;
    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_mul_fix;
    logic [WIDTH-1:0]   w_quot;
    logic [WIDTH-1:0]   w_rem;

    assign w_accept    = start && ((r_state == IDLE) || (r_state == DONE));
    assign w_iterative = (opcode == OP_MUL) || ((opcode == OP_DIV) && (b != '0));
    assign w_sh        = b[SHW-1:0];
    assign w_abs_a     = a[M] ? -a : a;
    assign w_abs_b     = b[M] ? -b : b;

    assign busy     = (r_state == ITER) || (r_state == FIX);
    assign done     = (r_state == DONE);
    assign result   = r_result;
    assign div_zero = r_div_zero;

    always_comb begin
        w_val = '0;
        case (opcode)
            OP_AND:  w_val = a & b;
            OP_OR:   w_val = a | b;
            OP_NOT:  w_val = ~b;
            OP_NEG:  w_val = -b;
            OP_ADD:  w_val = a + b;
            OP_SUB:  w_val = a - b;
            OP_DIV:  w_val = '1;
            OP_SHR:  w_val = a >> w_sh;
            OP_SHRA: w_val = $unsigned($signed(a) >>> w_sh);
            OP_SHL:  w_val = a << w_sh;
            // A shift by the full WIDTH yields zero, so an amount of 0 needs no special case
            OP_ROR:  w_val = (a >> w_sh) | (a << (WIDTH - int'(w_sh)));
            OP_ROL:  w_val = (a << w_sh) | (a >> (WIDTH - int'(w_sh)));
            default: w_val = '0;
        endcase
    end

    // Divide-by-zero: quotient all ones, remainder is the dividend
    assign w_single = (opcode == OP_DIV) ? {a, {WIDTH{1'b1}}} : {{WIDTH{1'b0}}, w_val};

    assign w_sum    = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_mcand} : '0);
    assign w_rem_sh = {r_hi, r_lo[M]};
    assign w_ge     = (w_rem_sh >= {1'b0, r_mcand});
    assign w_diff   = w_rem_sh[WIDTH-1:0] - r_mcand;

    assign w_prod    = {r_hi, r_lo};
    assign w_mul_fix = (r_sa ^ r_sb) ? -w_prod : w_prod;
    assign w_quot    = (r_sa ^ r_sb) ? -r_lo : r_lo;
    assign w_rem     = r_sa ? -r_hi : r_hi;

    always_ff @(posedge clk) begin
        if (!clr_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE, DONE: begin
                if (start) w_next = w_iterative ? ITER : DONE;
                else       w_next = IDLE;
            end
            ITER:    if (r_cnt == CW'(1)) w_next = FIX;
            FIX:     w_next = DONE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            r_hi       <= '0;
            r_lo       <= '0;
            r_mcand    <= '0;
            r_sa       <= 1'b0;
            r_sb       <= 1'b0;
            r_is_div   <= 1'b0;
            r_cnt      <= '0;
            r_result   <= '0;
            r_div_zero <= 1'b0;
        end else if (w_accept) begin
            r_div_zero <= (opcode == OP_DIV) && (b == '0);
            if (w_iterative) begin
                r_hi     <= '0;
                r_lo     <= w_abs_a;
                r_mcand  <= w_abs_b;
                r_sa     <= a[M];
                r_sb     <= b[M];
                r_is_div <= (opcode == OP_DIV);
                r_cnt    <= CW'(WIDTH);
            end else begin
                r_result <= w_single;
            end
        end else if (r_state == ITER) begin
            r_cnt <= r_cnt - CW'(1);
            if (r_is_div) begin
                // Restoring step: r_hi is the partial remainder, r_lo shifts dividend out and quotient in
                r_hi <= w_ge ? w_diff : w_rem_sh[WIDTH-1:0];
                r_lo <= {r_lo[WIDTH-2:0], w_ge};
            end else begin
                r_hi <= w_sum[WIDTH:1];
                r_lo <= {w_sum[0], r_lo[WIDTH-1:1]};
            end
        end else if (r_state == FIX) begin
            r_result <= r_is_div ? {w_rem, w_quot} : w_mul_fix;
        end
    end

`ifdef ALU_FLAGS_EN
    logic [3:0] r_flags;
    logic [3:0] w_flags_single;
    logic [3:0] w_flags_fix;

    always_comb begin
        w_flags_single = {w_val[M], (w_val == '0), 2'b00};
        case (opcode)
            OP_ADD: begin
                w_flags_single[1] = (a[M] & b[M]) | ((a[M] | b[M]) & ~w_val[M]);
                w_flags_single[0] = (a[M] == b[M]) && (w_val[M] != a[M]);
            end
            OP_SUB: begin
                w_flags_single[1] = (a >= b);
                w_flags_single[0] = (a[M] != b[M]) && (w_val[M] != a[M]);
            end
            OP_NEG:  w_flags_single[0] = (b == {1'b1, {(WIDTH-1){1'b0}}});
            default: ;
        endcase
        if (r_is_div) w_flags_fix = {w_quot[M], (w_quot == '0), 2'b00};
        else          w_flags_fix = {w_mul_fix[2*WIDTH-1], (w_mul_fix == '0), 2'b00};
    end

    always_ff @(posedge clk) begin
        if (!clr_n)                                r_flags <= '0;
        else if (w_accept && !w_iterative)         r_flags <= w_flags_single;
        else if (!w_accept && (r_state == FIX))    r_flags <= w_flags_fix;
    end

    assign flags = r_flags;
`endif

endmodule

// File: tb/tb_seq_alu.sv
// Directed testbench for seq_alu at WIDTH=32; define ALU_FLAGS_EN to also check flags.
module tb_seq_alu;

    localparam int W = 32;

    localparam logic [4:0] OP_AND  = 5'b00000;
    localparam logic [4:0] OP_OR   = 5'b00001;
    localparam logic [4:0] OP_NOT  = 5'b00010;
    localparam logic [4:0] OP_NEG  = 5'b00011;
    localparam logic [4:0] OP_ADD  = 5'b00100;
    localparam logic [4:0] OP_SUB  = 5'b00101;
    localparam logic [4:0] OP_MUL  = 5'b00110;
    localparam logic [4:0] OP_DIV  = 5'b00111;
    localparam logic [4:0] OP_SHR  = 5'b01000;
    localparam logic [4:0] OP_SHRA = 5'b01001;
    localparam logic [4:0] OP_SHL  = 5'b01010;
    localparam logic [4:0] OP_ROR  = 5'b01011;
    localparam logic [4:0] OP_ROL  = 5'b01100;
    localparam logic [4:0] OP_UNDEF = 5'b11111;

    logic           clk = 1'b0;
    logic           clr_n = 1'b0;
    logic           start = 1'b0;
    logic [4:0]     opcode = '0;
    logic [W-1:0]   a = '0;
    logic [W-1:0]   b = '0;
    logic           busy;
    logic           done;
    logic [2*W-1:0] result;
    logic           div_zero;
`ifdef ALU_FLAGS_EN
    logic [3:0]     flags;
`endif

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [4:0]     op;
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        logic [2*W-1:0] res;
        logic [3:0]     fl;
    } vec_t;

    seq_alu #(.WIDTH(W)) dut (
        .clk      (clk),
        .clr_n    (clr_n),
        .start    (start),
        .opcode   (opcode),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .div_zero (div_zero)
`ifdef ALU_FLAGS_EN
        ,
        .flags    (flags)
`endif
    );

    always #5 clk = ~clk;

    // Issues one op and counts edges (sampling edge = 1) until done; lat = -1 on timeout.
    // Operands are scrambled after acceptance to expose any re-sampling.
    task automatic run_op(input logic [4:0] op, input logic [W-1:0] ia, input logic [W-1:0] ib,
                          output int lat, output int nbusy);
        @(negedge clk);
        start = 1'b1; opcode = op; a = ia; b = ib;
        lat = -1; nbusy = 0;
        for (int n = 1; n <= 100 && lat < 0; n++) begin
            @(posedge clk); #1;
            start = 1'b0; opcode = OP_AND; a = ~ia; b = ~ib;
            if (busy) nbusy++;
            if (done) lat = n;
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        n_vec++; if (busy !== 1'b0)     begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_vec++; if (done !== 1'b0)     begin n_err++; $display("FAIL reset_done: got %b want 0", done); end
        n_vec++; if (result !== '0)     begin n_err++; $display("FAIL reset_result: got %h want 0", result); end
        n_vec++; if (div_zero !== 1'b0) begin n_err++; $display("FAIL reset_div_zero: got %b want 0", div_zero); end
`ifdef ALU_FLAGS_EN
        n_vec++; if (flags !== 4'b0000) begin n_err++; $display("FAIL reset_flags: got %b want 0000", flags); end
`endif
        @(negedge clk);
        clr_n = 1'b1;
    endtask

    task automatic test_single_cycle();
        vec_t v [18];
        int lat, nb;
        v[0]  = '{OP_ADD,   32'h7FFF_FFFF, 32'h0000_0001, 64'h0000_0000_8000_0000, 4'b1001};
        v[1]  = '{OP_ADD,   32'hFFFF_FFFF, 32'h0000_0001, 64'h0000_0000_0000_0000, 4'b0110};
        v[2]  = '{OP_SUB,   32'h0000_0003, 32'h0000_0005, 64'h0000_0000_FFFF_FFFE, 4'b1000};
        v[3]  = '{OP_SUB,   32'h0000_0005, 32'h0000_0003, 64'h0000_0000_0000_0002, 4'b0010};
        v[4]  = '{OP_SUB,   32'h8000_0000, 32'h0000_0001, 64'h0000_0000_7FFF_FFFF, 4'b0011};
        v[5]  = '{OP_NEG,   32'h0000_0000, 32'h8000_0000, 64'h0000_0000_8000_0000, 4'b1001};
        v[6]  = '{OP_NEG,   32'h0000_0000, 32'h0000_0005, 64'h0000_0000_FFFF_FFFB, 4'b1000};
        v[7]  = '{OP_AND,   32'hF0F0_F0F0, 32'hFF00_FF00, 64'h0000_0000_F000_F000, 4'b1000};
        v[8]  = '{OP_OR,    32'h0F0F_0000, 32'h0000_F0F0, 64'h0000_0000_0F0F_F0F0, 4'b0000};
        v[9]  = '{OP_NOT,   32'h0000_0000, 32'h1234_5678, 64'h0000_0000_EDCB_A987, 4'b1000};
        v[10] = '{OP_SHR,   32'h8000_0000, 32'h0000_001F, 64'h0000_0000_0000_0001, 4'b0000};
        v[11] = '{OP_SHL,   32'h0000_0001, 32'h0000_0024, 64'h0000_0000_0000_0010, 4'b0000};
        v[12] = '{OP_ROL,   32'h8000_0001, 32'h0000_0001, 64'h0000_0000_0000_0003, 4'b0000};
        v[13] = '{OP_ROR,   32'hDEAD_BEEF, 32'h0000_0020, 64'h0000_0000_DEAD_BEEF, 4'b1000};
        v[14] = '{OP_SHRA,  32'h4000_0000, 32'h0000_0004, 64'h0000_0000_0400_0000, 4'b0000};
        v[15] = '{OP_UNDEF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0000, 4'b0100};
        v[16] = '{OP_ROL,   32'h1234_5678, 32'h0000_0004, 64'h0000_0000_2345_6781, 4'b0000};
        v[17] = '{OP_SHR,   32'hF000_0000, 32'h0000_0040, 64'h0000_0000_F000_0000, 4'b1000};
        for (int i = 0; i < 18; i++) begin
            run_op(v[i].op, v[i].a, v[i].b, lat, nb);
            n_vec++; if (lat !== 1) begin n_err++; $display("FAIL single[%0d]_latency: got %0d want 1", i, lat); end
            n_vec++; if (nb !== 0)  begin n_err++; $display("FAIL single[%0d]_busy_cycles: got %0d want 0", i, nb); end
            n_vec++; if (result !== v[i].res) begin n_err++; $display("FAIL single[%0d]_result: got %h want %h", i, result, v[i].res); end
            n_vec++; if (div_zero !== 1'b0) begin n_err++; $display("FAIL single[%0d]_div_zero: got %b want 0", i, div_zero); end
`ifdef ALU_FLAGS_EN
            n_vec++; if (flags !== v[i].fl) begin n_err++; $display("FAIL single[%0d]_flags: got %b want %b", i, flags, v[i].fl); end
`endif
        end
    endtask

    task automatic test_mul_div();
        vec_t v [10];
        int lat, nb;
        v[0] = '{OP_MUL, 32'hFFFF_FFFD, 32'h0000_0007, 64'hFFFF_FFFF_FFFF_FFEB, 4'b1000};
        v[1] = '{OP_MUL, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 4'b0000};
        v[2] = '{OP_MUL, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFF_8000_0001, 4'b1000};
        v[3] = '{OP_MUL, 32'h0000_0000, 32'h0000_0005, 64'h0000_0000_0000_0000, 4'b0100};
        v[4] = '{OP_DIV, 32'hFFFF_FFF9, 32'h0000_0002, 64'hFFFF_FFFF_FFFF_FFFD, 4'b1000};
        v[5] = '{OP_DIV, 32'h0000_0007, 32'hFFFF_FFFE, 64'h0000_0001_FFFF_FFFD, 4'b1000};
        v[6] = '{OP_DIV, 32'h0000_0064, 32'h0000_0007, 64'h0000_0002_0000_000E, 4'b0000};
        v[7] = '{OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, 4'b1000};
        v[8] = '{OP_DIV, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 64'hFFFF_FFFE_0000_000E, 4'b0000};
        v[9] = '{OP_DIV, 32'h0000_0003, 32'h0000_0005, 64'h0000_0003_0000_0000, 4'b0100};
        for (int i = 0; i < 10; i++) begin
            run_op(v[i].op, v[i].a, v[i].b, lat, nb);
            n_vec++; if (lat !== W + 2) begin n_err++; $display("FAIL iter[%0d]_latency: got %0d want %0d", i, lat, W + 2); end
            n_vec++; if (nb !== W + 1)  begin n_err++; $display("FAIL iter[%0d]_busy_cycles: got %0d want %0d", i, nb, W + 1); end
            n_vec++; if (result !== v[i].res) begin n_err++; $display("FAIL iter[%0d]_result: got %h want %h", i, result, v[i].res); end
            n_vec++; if (div_zero !== 1'b0) begin n_err++; $display("FAIL iter[%0d]_div_zero: got %b want 0", i, div_zero); end
`ifdef ALU_FLAGS_EN
            n_vec++; if (flags !== v[i].fl) begin n_err++; $display("FAIL iter[%0d]_flags: got %b want %b", i, flags, v[i].fl); end
`endif
        end
    endtask

    task automatic test_div_zero();
        int lat, nb;
        run_op(OP_DIV, 32'h0000_0005, 32'h0000_0000, lat, nb);
        n_vec++; if (lat !== 1) begin n_err++; $display("FAIL dz_latency: got %0d want 1", lat); end
        n_vec++; if (result !== 64'h0000_0005_FFFF_FFFF) begin n_err++; $display("FAIL dz_result: got %h want 00000005ffffffff", result); end
        n_vec++; if (div_zero !== 1'b1) begin n_err++; $display("FAIL dz_flag: got %b want 1", div_zero); end
`ifdef ALU_FLAGS_EN
        n_vec++; if (flags !== 4'b1000) begin n_err++; $display("FAIL dz_flags: got %b want 1000", flags); end
`endif
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL dz_done_pulse[%0d]: got %b want 0", k, done); end
        end
        n_vec++; if (result !== 64'h0000_0005_FFFF_FFFF) begin n_err++; $display("FAIL dz_result_hold: got %h want 00000005ffffffff", result); end
        n_vec++; if (div_zero !== 1'b1) begin n_err++; $display("FAIL dz_flag_hold: got %b want 1", div_zero); end
        run_op(OP_DIV, 32'hFFFF_FFFF, 32'h0000_0000, lat, nb);
        n_vec++; if (result !== 64'hFFFF_FFFF_FFFF_FFFF) begin n_err++; $display("FAIL dz_neg_result: got %h want ffffffffffffffff", result); end
        n_vec++; if (div_zero !== 1'b1) begin n_err++; $display("FAIL dz_neg_flag: got %b want 1", div_zero); end
        run_op(OP_ADD, 32'h0000_0002, 32'h0000_0002, lat, nb);
        n_vec++; if (div_zero !== 1'b0) begin n_err++; $display("FAIL dz_clear: got %b want 0", div_zero); end
        n_vec++; if (result !== 64'h4) begin n_err++; $display("FAIL dz_clear_result: got %h want 4", result); end
    endtask

    task automatic test_back_to_back();
        int lat, nb;
        run_op(OP_ROR, 32'h0000_0001, 32'h0000_0021, lat, nb);
        n_vec++; if (lat !== 1) begin n_err++; $display("FAIL b2b_ror_latency: got %0d want 1", lat); end
        n_vec++; if (result !== 64'h0000_0000_8000_0000) begin n_err++; $display("FAIL b2b_ror_result: got %h want 80000000", result); end
        run_op(OP_SHRA, 32'h8000_0000, 32'h0000_0004, lat, nb);
        n_vec++; if (lat !== 1) begin n_err++; $display("FAIL b2b_shra_latency: got %0d want 1", lat); end
        n_vec++; if (result !== 64'h0000_0000_F800_0000) begin n_err++; $display("FAIL b2b_shra_result: got %h want f8000000", result); end
        run_op(OP_MUL, 32'hFFFF_FFFD, 32'h0000_0007, lat, nb);
        n_vec++; if (lat !== W + 2) begin n_err++; $display("FAIL b2b_mul_latency: got %0d want %0d", lat, W + 2); end
        n_vec++; if (result !== 64'hFFFF_FFFF_FFFF_FFEB) begin n_err++; $display("FAIL b2b_mul_result: got %h want ffffffffffffffeb", result); end
    endtask

    task automatic test_ignore_busy();
        int lat;
        @(negedge clk);
        start = 1'b1; opcode = OP_MUL; a = 32'd6; b = 32'd7;
        lat = -1;
        for (int n = 1; n <= 100 && lat < 0; n++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (n == 2) begin start = 1'b1; opcode = OP_ADD; a = 32'd1; b = 32'd1; end
            if (done) lat = n;
        end
        start = 1'b0;
        n_vec++; if (lat !== W + 2) begin n_err++; $display("FAIL ignore_latency: got %0d want %0d", lat, W + 2); end
        n_vec++; if (result !== 64'h2A) begin n_err++; $display("FAIL ignore_result: got %h want 2a", result); end
        @(posedge clk); #1;
        n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL ignore_done_once: got %b want 0", done); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL ignore_busy_after: got %b want 0", busy); end
        n_vec++; if (result !== 64'h2A) begin n_err++; $display("FAIL ignore_result_hold: got %h want 2a", result); end
    endtask

    task automatic test_abort();
        logic saw_done;
        saw_done = 1'b0;
        @(negedge clk);
        start = 1'b1; opcode = OP_MUL; a = 32'hFFFF_FFFD; b = 32'd7;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (k < 10 && done) saw_done = 1'b1;
            if (k == 4) begin start = 1'b1; opcode = OP_DIV; a = 32'd9; b = 32'd0; end
            if (k == 5) begin
                n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL abort_ignored_start_busy: got %b want 1", busy); end
            end
            if (k == 9) begin
                n_vec++; if (result !== 64'h2A) begin n_err++; $display("FAIL abort_result_held: got %h want 2a", result); end
                clr_n = 1'b0;
            end
        end
        n_vec++; if (saw_done !== 1'b0) begin n_err++; $display("FAIL abort_early_done: got %b want 0", saw_done); end
        n_vec++; if (busy !== 1'b0)     begin n_err++; $display("FAIL abort_busy: got %b want 0", busy); end
        n_vec++; if (result !== '0)     begin n_err++; $display("FAIL abort_result: got %h want 0", result); end
        n_vec++; if (done !== 1'b0)     begin n_err++; $display("FAIL abort_done: got %b want 0", done); end
        n_vec++; if (div_zero !== 1'b0) begin n_err++; $display("FAIL abort_div_zero: got %b want 0", div_zero); end
`ifdef ALU_FLAGS_EN
        n_vec++; if (flags !== 4'b0000) begin n_err++; $display("FAIL abort_flags: got %b want 0000", flags); end
`endif
        clr_n = 1'b1;
        saw_done = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (done) saw_done = 1'b1;
        end
        n_vec++; if (saw_done !== 1'b0) begin n_err++; $display("FAIL abort_late_done: got %b want 0", saw_done); end
    endtask

    initial begin
        test_reset();
        test_single_cycle();
        test_mul_div();
        test_div_zero();
        test_back_to_back();
        test_ignore_busy();
        test_abort();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
